fifo_wr_arbiter: RTL

Round-robin write arbiter that shares the single write port of a `FIFO` instance (parameters `W`, `D`) between `N` independent producers. Each producer has a valid/ready handshake. The arbiter drives the FIFO's `wrt_en`/`data_in` and honours `full`, so a producer beat is never dropped and never duplicated. It sits directly in front of the FIFO write side; the read side is untouched.

---
 rtl/fifo_pkg.sv | 9 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 23 ++
 rtl/fifo_wr_arbiter.sv | 58 +++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO defaults, id type and id-width helper.
package fifo_pkg;
    localparam int FIFO_W_DEF = 32;
    localparam int FIFO_D_DEF = 3;
    typedef logic [3:0] fifo_id_t;
    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational cyclic priority picker, first set req at or after start.
module rr_pick #(
    parameter int N = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] start,
    output logic [IDW-1:0] winner,
    output logic           any
);
    logic [IDW:0] sum;
    assign any = |req;
    // Descending scan so the smallest cyclic offset from start is written last.
    always_comb begin
        winner = '0;
        sum = '0;
        for (int i = N - 1; i >= 0; i--) begin
            sum = {1'b0, start} + (IDW + 1)'(i);
            if (sum >= (IDW + 1)'(N)) sum = sum - (IDW + 1)'(N);
            if (req[sum[IDW-1:0]]) winner = sum[IDW-1:0];
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin N-producer arbiter in front of a FIFO write port.
// Optional burst hold compiled in with FIFO_ARB_HOLD_EN.
module fifo_wr_arbiter import fifo_pkg::*; #(
    parameter int W = FIFO_W_DEF,
    parameter int N = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    input  logic [N*W-1:0]       req_data,
    output logic [N-1:0]         req_ready,
    input  logic                 fifo_full,
    output logic                 fifo_wrt_en,
    output logic [W-1:0]         fifo_data_in,
    output logic [idw(N)-1:0]    grant_id
);
    localparam int IDW = idw(N);
    localparam logic [IDW-1:0] LAST = IDW'(N - 1);
    logic [IDW-1:0] last_grant, start, pick, winner;
    logic any, hold;
    assign start = (last_grant == LAST) ? '0 : last_grant + 1'b1;
    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .req(req_valid),
        .start(start),
        .winner(pick),
        .any(any)
    );
`ifdef FIFO_ARB_HOLD_EN
    logic [7:0] burst_cnt;
    logic owner_active;
    assign hold = owner_active & req_valid[last_grant] & (burst_cnt < 8'(MAX_BURST));
    // A full stall with hold intact leaves the burst untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt <= '0;
            owner_active <= 1'b0;
        end else if (fifo_wrt_en) begin
            burst_cnt <= hold ? burst_cnt + 8'd1 : 8'd1;
            owner_active <= 1'b1;
        end else if (!hold) begin
            burst_cnt <= '0;
            owner_active <= 1'b0;
        end
    end
`else
    assign hold = 1'b0;
`endif
    assign winner = hold ? last_grant : pick;
    assign fifo_wrt_en = any & ~fifo_full & ~rst;
    assign req_ready = fifo_wrt_en ? (N'(1) << winner) : '0;
    assign grant_id = any ? winner : last_grant;
    assign fifo_data_in = req_data[grant_id*W +: W];
    always_ff @(posedge clk) begin
        if (rst) last_grant <= LAST;
        else if (fifo_wrt_en) last_grant <= winner;
    end
endmodule
